// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage valid/ready bitwise logic unit with zero and parity flags.
// Define LOGIC_UNIT_POPCNT_EN to make op 111 a Hamming-distance popcount instead of NOT A.
module logic_unit_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] cout1,
    output logic             zero,
    output logic             parity
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // the sender holds its payload stable and keeps valid high until that edge.
    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NOR  = 3'b011,
        OP_XNOR = 3'b100,
        OP_NAND = 3'b101,
        OP_ANDN = 3'b110,
        OP_ALT  = 3'b111
    } op_e;

    logic             r_s1_valid;
    op_e              r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_cout1;
    logic             r_zero;
    logic             r_parity;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic [WIDTH-1:0] w_result;

    assign w_s2_adv = !r_out_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;

`ifdef LOGIC_UNIT_POPCNT_EN
    localparam int PCW = $clog2(WIDTH) + 1;
    logic [WIDTH-1:0] w_diff;
    logic [PCW-1:0]   w_popcnt;

    always_comb begin
        w_diff   = r_s1_a ^ r_s1_b;
        w_popcnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_popcnt = w_popcnt + PCW'(w_diff[i]);
        end
    end
`endif

    always_comb begin
        w_result = '0;
        case (r_s1_op)
            OP_AND:  w_result = r_s1_a & r_s1_b;
            OP_OR:   w_result = r_s1_a | r_s1_b;
            OP_XOR:  w_result = r_s1_a ^ r_s1_b;
            OP_NOR:  w_result = ~(r_s1_a | r_s1_b);
            OP_XNOR: w_result = ~(r_s1_a ^ r_s1_b);
            OP_NAND: w_result = ~(r_s1_a & r_s1_b);
            OP_ANDN: w_result = r_s1_a & ~r_s1_b;
`ifdef LOGIC_UNIT_POPCNT_EN
            OP_ALT:  w_result = WIDTH'(w_popcnt);
`else
            OP_ALT:  w_result = ~r_s1_a;
`endif
            default: w_result = '0;
        endcase
    end

    // S1: operand capture; holds when S2 is stalled and S1 is occupied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= OP_AND;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_op <= op_e'(op);
                r_s1_a  <= In1;
                r_s1_b  <= In2;
            end
        end
    end

    // S2: result and flags are registered together so they always agree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_cout1     <= '0;
            r_zero      <= 1'b0;
            r_parity    <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_cout1  <= w_result;
                r_zero   <= (w_result == '0);
                r_parity <= ^w_result;
            end
        end
    end

    assign in_ready  = w_s1_adv;
    assign out_valid = r_out_valid;
    assign cout1     = r_cout1;
    assign zero      = r_zero;
    assign parity    = r_parity;

endmodule
